// File: rtl/mem_acc_pkg.sv
// Shared types and sizing for the memory access unit.
//   acc_state_t : access FSM states
//   TIMEOUT_DEF : default abort limit in REQ+WAIT_RSP cycles
//   TIMER_W     : timer width for the default limit
package mem_acc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } acc_state_t;

  // Counter width able to hold 0 .. n-1 (at least one bit).
  function automatic int unsigned tmr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned TIMER_W     = tmr_width(TIMEOUT_DEF);

endpackage

// File: rtl/mem_acc_if.sv
// Controller-side and memory-side signals of the memory access unit.
//   master : the access unit (drives acc_stall/acc_rdata/acc_err and mem_*)
//   slave  : the environment (controller drives acc_*, memory drives gnt/rvalid/rdata)
interface mem_acc_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          acc_req;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_stall;
  logic [DW-1:0] acc_rdata;
  logic          acc_err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  acc_req, acc_we, acc_addr, acc_wdata,
    output acc_stall, acc_rdata, acc_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output acc_req, acc_we, acc_addr, acc_wdata,
    input  acc_stall, acc_rdata, acc_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/acc_timer.sv
// Access timeout counter.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : restart count at 0 (wins over en_i)
//   en_i       : advance count by one
//   expire_o   : count has reached LIMIT-1 (registered)
module acc_timer #(
  parameter int unsigned W     = 4,
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expire_q, expire_d;

  // Next count; expire is precomputed from it so the flag tracks cnt_q exactly.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
    expire_d = (cnt_d == W'(LIMIT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= (LIMIT <= 1);
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns one controller access (fetch/load/store) into a
// grant/response transaction on a variable-latency shared memory, stalling
// the controller until the access completes.
//   clk, reset : clock, async active-low reset
//   bus        : controller side (acc_req/we/addr/wdata in; acc_stall/rdata/err out)
//                memory side (mem_req/we/addr/wdata out; mem_gnt/rvalid/rdata in)
module mem_access_unit
  import mem_acc_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mem_acc_if.master    bus
);

  localparam int unsigned TW = tmr_width(TIMEOUT);

  acc_state_t    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] acc_rdata_q, acc_rdata_d;
  logic          acc_err_q, acc_err_d;

  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_exp;

  // Counts cycles spent in REQ and WAIT_RSP for the abort check.
  acc_timer #(
    .W     (TW),
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_exp)
  );

  assign tmr_en = (state_q == REQ) || (state_q == WAIT_RSP);

  // Next-state and register updates; a grant or rvalid always beats expiry.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    acc_rdata_d = acc_rdata_q;
    acc_err_d   = acc_err_q;
    tmr_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.acc_req) begin
          mem_addr_d  = bus.acc_addr;
          mem_wdata_d = bus.acc_wdata;
          mem_we_d    = bus.acc_we;
          acc_err_d   = 1'b0;
          if (bus.acc_addr[1:0] != 2'b00) begin
            acc_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            mem_req_d = 1'b1;
            tmr_clr   = 1'b1;
            state_d   = REQ;
          end
        end
      end

      REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? DONE : WAIT_RSP;
        end else if (tmr_exp) begin
          mem_req_d = 1'b0;
          acc_err_d = 1'b1;
          state_d   = DONE;
        end
      end

      WAIT_RSP: begin
        if (bus.mem_rvalid) begin
          acc_rdata_d = bus.mem_rdata;
          state_d     = DONE;
        end else if (tmr_exp) begin
          acc_err_d = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      acc_rdata_q <= '0;
      acc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      acc_rdata_q <= acc_rdata_d;
      acc_err_q   <= acc_err_d;
    end
  end

  // Stall is combinational so the controller holds in the cycle it requests.
  assign bus.acc_stall = bus.acc_req && (state_q != DONE);
  assign bus.acc_rdata = acc_rdata_q;
  assign bus.acc_err   = acc_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected
// completions and memory phases; a negedge monitor pops and compares.
module tb_mem_access_unit;

  logic clk;
  logic reset;

  mem_acc_if #(.AW(32), .DW(32)) bus ();

  mem_access_unit #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } acc_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } mem_exp_t;

  acc_exp_t    acc_q[$];
  mem_exp_t    mem_q[$];
  acc_exp_t    ae;
  mem_exp_t    me;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          stall_cnt = 0;
  int          mem_len = 0;

  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic [31:0] rv_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Memory model: grant after gnt_dly waiting cycles, rvalid rv_dly cycles after the gnt cycle + 1.
  initial begin : responder
    int  req_cyc;
    int  rv_cnt;
    bit  pend;
    req_cyc = 0;
    rv_cnt  = 0;
    pend    = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!reset) begin
        pend    = 1'b0;
        req_cyc = 0;
      end else begin
        if (pend) begin
          if (rv_cnt == rv_dly) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rv_data;
            pend           = 1'b0;
          end else begin
            rv_cnt++;
          end
        end
        if (bus.mem_req) begin
          if (req_cyc == gnt_dly) begin
            bus.mem_gnt = 1'b1;
            req_cyc     = 0;
            if (!bus.mem_we) begin
              pend   = 1'b1;
              rv_cnt = 0;
            end
          end else begin
            req_cyc++;
          end
        end else begin
          req_cyc = 0;
        end
      end
    end
  end

  // Monitor: completions on the controller side, request phases on the memory side.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_len > 0) begin
        if (mem_q.size() == 0) fail_now("mem_phase_unexpected");
        else begin
          me = mem_q.pop_front();
          chk("mem_req_cycles", 32'(mem_len), 32'(me.len));
        end
      end
      stall_cnt = 0;
      mem_len   = 0;
    end else begin
      if (bus.acc_req) begin
        if (bus.acc_stall) begin
          stall_cnt++;
        end else begin
          if (acc_q.size() == 0) fail_now("completion_unexpected");
          else begin
            ae = acc_q.pop_front();
            chk("stall_cycles", 32'(stall_cnt), 32'(ae.stalls));
            chk("acc_err", 32'(bus.acc_err), 32'(ae.err));
            chk("acc_rdata", bus.acc_rdata, ae.rdata);
          end
          stall_cnt = 0;
          done_cnt++;
        end
      end
      if (bus.mem_req) begin
        if (mem_q.size() == 0) fail_now("mem_req_unexpected");
        else begin
          chk("mem_addr", bus.mem_addr, mem_q[0].addr);
          chk("mem_we", 32'(bus.mem_we), 32'(mem_q[0].we));
          chk("mem_wdata", bus.mem_wdata, mem_q[0].wdata);
        end
        mem_len++;
      end else if (mem_len > 0) begin
        if (mem_q.size() == 0) fail_now("mem_phase_unexpected");
        else begin
          me = mem_q.pop_front();
          chk("mem_req_cycles", 32'(mem_len), 32'(me.len));
        end
        mem_len = 0;
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.acc_we    = we;
    bus.acc_addr  = addr;
    bus.acc_wdata = wdata;
    bus.acc_req   = 1'b1;
  endtask

  // One access with expected completion; returns #1 after the edge ending DONE, acc_req still high.
  task automatic do_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int gd, input int rd, input logic [31:0] rdat,
                        input int exp_stall, input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_len);
    int start;
    int n;
    acc_exp_t a;
    mem_exp_t m;
    a.rdata  = exp_rdata;
    a.err    = exp_err;
    a.stalls = exp_stall;
    acc_q.push_back(a);
    if (exp_len > 0) begin
      m.addr  = addr;
      m.we    = we;
      m.wdata = wdata;
      m.len   = exp_len;
      mem_q.push_back(m);
    end
    gnt_dly = gd;
    rv_dly  = rd;
    rv_data = rdat;
    drive(we, addr, wdata);
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt == start) begin
      fail_now("completion_timeout");
      bus.acc_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    bus.acc_req   = 1'b0;
    bus.acc_we    = 1'b0;
    bus.acc_addr  = '0;
    bus.acc_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_acc_stall", 32'(bus.acc_stall), 32'd0);
    chk("rst_acc_rdata", bus.acc_rdata, 32'h0);
    chk("rst_acc_err", 32'(bus.acc_err), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait read.
    do_acc(1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 1);
    bus.acc_req = 1'b0;
    // Write with grant delayed 4 cycles.
    do_acc(1'b1, 32'h204, 32'h12345678, 4, 0, 32'h0, 6, 1'b0, 32'hDEADBEEF, 5);
    bus.acc_req = 1'b0;
    // Misaligned read: no memory phase.
    do_acc(1'b0, 32'h102, 32'h0, 0, 0, 32'h0, 1, 1'b1, 32'hDEADBEEF, 0);
    bus.acc_req = 1'b0;
    // Read timeout; rvalid arrives in DONE and must be ignored.
    do_acc(1'b0, 32'h108, 32'h0, 0, 15, 32'hBAD0BAD0, 17, 1'b1, 32'hDEADBEEF, 1);
    bus.acc_req = 1'b0;
    @(negedge clk);
    chk("late_rvalid_ignored", bus.acc_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    // rvalid coincides with expiry: data wins, no error.
    do_acc(1'b0, 32'h10C, 32'h0, 0, 14, 32'hCAFEF00D, 17, 1'b0, 32'hCAFEF00D, 1);
    bus.acc_req = 1'b0;

    // Back-to-back misaligned, fetch, load with acc_req held across DONE.
    do_acc(1'b0, 32'h301, 32'h0, 0, 0, 32'h0, 1, 1'b1, 32'hCAFEF00D, 0);
    do_acc(1'b0, 32'h300, 32'h0, 0, 0, 32'h11111111, 3, 1'b0, 32'h11111111, 1);
    do_acc(1'b0, 32'h304, 32'h0, 0, 0, 32'h22222222, 3, 1'b0, 32'h22222222, 1);
    bus.acc_req = 1'b0;

    // Write grant coincides with expiry, then write with no grant at all.
    do_acc(1'b1, 32'h208, 32'hA5A5A5A5, 15, 0, 32'h0, 17, 1'b0, 32'h22222222, 16);
    bus.acc_req = 1'b0;
    do_acc(1'b1, 32'h20C, 32'h5A5A5A5A, 16, 0, 32'h0, 17, 1'b1, 32'h22222222, 16);
    bus.acc_req = 1'b0;

    // Reset while a write waits in REQ.
    begin
      mem_exp_t m;
      m.addr = 32'h600; m.we = 1'b1; m.wdata = 32'h66666666; m.len = 1;
      mem_q.push_back(m);
    end
    gnt_dly = 10;
    drive(1'b1, 32'h600, 32'h66666666);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.acc_req = 1'b0;
    #1;
    chk("rstreq_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rstreq_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rstreq_mem_addr", bus.mem_addr, 32'h0);
    chk("rstreq_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rstreq_acc_err", 32'(bus.acc_err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset while a read waits in WAIT_RSP.
    do_acc(1'b0, 32'h440, 32'h0, 0, 0, 32'h44444444, 3, 1'b0, 32'h44444444, 1);
    bus.acc_req = 1'b0;
    begin
      mem_exp_t m;
      m.addr = 32'h400; m.we = 1'b0; m.wdata = 32'h0; m.len = 1;
      mem_q.push_back(m);
    end
    gnt_dly = 0;
    rv_dly  = 5;
    rv_data = 32'h99999999;
    drive(1'b0, 32'h400, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.acc_req = 1'b0;
    #1;
    chk("rstwait_acc_rdata", bus.acc_rdata, 32'h0);
    chk("rstwait_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rstwait_acc_stall", 32'(bus.acc_stall), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Read after reset release completes normally.
    do_acc(1'b0, 32'h500, 32'h0, 0, 0, 32'h55AA55AA, 3, 1'b0, 32'h55AA55AA, 1);
    bus.acc_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
